stream_capture_router: RTL and testbench

//  Wishbone-controlled AXI4-Stream crossbar that routes NCHAN ADC input streams to NBUF buffer outputs.

---
 rtl/stream_capture_router.sv | 232 +++++++++++++++++++++++
 tb/tb_stream_capture_router.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_capture_router.sv
// stream_capture_router
//   Wishbone-controlled AXI4-Stream crossbar. It routes NCHAN ADC input
//   streams to NBUF buffer outputs. Each output has a one-beat register stage
//   and runs in one of two modes: continuous pass-through, or a one-shot
//   capture of LEN beats.
//
// Ports
//   wb_clk_i, wb_rst_i        single clock, synchronous active-high reset
//   wb_cyc_i .. wb_sel_i      Wishbone slave inputs (only wb_adr_i[4:2] is decoded)
//   wb_dat_o, wb_ack_o        Wishbone read data and acknowledge
//   wb_err_o, wb_rty_o        tied low
//   adc_tdata/tvalid/tready   NCHAN input streams; channel c occupies [c*DW +: DW]
//   buf_tdata/tvalid/tready   NBUF output streams; buffer b occupies [b*DW +: DW]
//
// Register map (wb_adr_i[4:2])
//   0 ID      RO  0x42534331 ("BSC1")
//   1 CTRL    RW  [NBUF-1:0] enable, [16] oneshot, [31] ARM strobe (reads 0)
//   2 SEL     RW  nibble b = source channel for buffer b (>= NCHAN means no source)
//   3 LEN     RW  [15:0] one-shot beat count
//   4 STATUS  RO  [7:0] DONE per buffer, [15:8] CAPT per buffer

module stream_capture_router #(
   parameter int NCHAN = 8,
   parameter int NBUF  = 4,
   parameter int DW    = 128
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic [21:0]         wb_adr_i,
   input  logic [31:0]         wb_dat_i,
   input  logic [3:0]          wb_sel_i,
   output logic [31:0]         wb_dat_o,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic                wb_rty_o,
   input  logic [NCHAN*DW-1:0] adc_tdata,
   input  logic [NCHAN-1:0]    adc_tvalid,
   output logic [NCHAN-1:0]    adc_tready,
   output logic [NBUF*DW-1:0]  buf_tdata,
   output logic [NBUF-1:0]     buf_tvalid,
   input  logic [NBUF-1:0]     buf_tready
);

   localparam logic [31:0] ID_VALUE   = 32'h4253_4331;

   localparam logic [1:0]  ST_OFF     = 2'd0;
   localparam logic [1:0]  ST_PASS    = 2'd1;
   localparam logic [1:0]  ST_CAPT    = 2'd2;
   localparam logic [1:0]  ST_DONE    = 2'd3;

   localparam logic [2:0]  REG_ID     = 3'd0;
   localparam logic [2:0]  REG_CTRL   = 3'd1;
   localparam logic [2:0]  REG_SEL    = 3'd2;
   localparam logic [2:0]  REG_LEN    = 3'd3;
   localparam logic [2:0]  REG_STATUS = 3'd4;

   logic              ack_q;
   logic [NBUF-1:0]   ctrl_en;
   logic              ctrl_oneshot;
   logic [3:0]        sel [NBUF];
   logic [15:0]       len;
   logic [1:0]        state [NBUF];
   logic [15:0]       cnt [NBUF];
   logic [NBUF-1:0]   stage_valid;
   logic [DW-1:0]     stage_data [NBUF];

   logic [2:0]        reg_idx;
   logic              wr_en;
   logic              arm;
   logic [NBUF-1:0]   eligible;
   logic [NBUF-1:0]   stage_free;
   logic [NBUF-1:0]   load;
   logic [DW-1:0]     src_data [NBUF];
   logic              unused_bits;

   assign reg_idx     = wb_adr_i[4:2];
   assign wr_en       = wb_cyc_i & wb_stb_i & wb_we_i & ~ack_q;
   assign arm         = wr_en & (reg_idx == REG_CTRL) & wb_dat_i[31] & wb_dat_i[16];
   assign wb_ack_o    = ack_q & wb_cyc_i;
   assign wb_err_o    = 1'b0;
   assign wb_rty_o    = 1'b0;
   assign buf_tvalid  = stage_valid;
   assign unused_bits = &{1'b0, wb_sel_i, wb_adr_i[21:5], wb_adr_i[1:0], wb_dat_i};

   // Bus interface and configuration registers. The write fires only on the
   // first cycle of a transaction (ack not yet raised), so it lands exactly once.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q        <= 1'b0;
         ctrl_en      <= '0;
         ctrl_oneshot <= 1'b0;
         len          <= 16'h0100;
         for (int b = 0; b < NBUF; b++)
            sel[b] <= (b < NCHAN) ? 4'(b) : 4'd0;
      end else begin
         ack_q <= wb_cyc_i & wb_stb_i & ~ack_q;
         if (wr_en) begin
            case (reg_idx)
               REG_CTRL: begin
                  ctrl_en      <= wb_dat_i[NBUF-1:0];
                  ctrl_oneshot <= wb_dat_i[16];
               end
               REG_SEL: begin
                  for (int b = 0; b < NBUF; b++)
                     sel[b] <= wb_dat_i[4*b +: 4];
               end
               REG_LEN:  len <= wb_dat_i[15:0];
               default: ;
            endcase
         end
      end
   end

   // Read mux is purely combinational from the address.
   always_comb begin
      wb_dat_o = '0;
      case (reg_idx)
         REG_ID:   wb_dat_o = ID_VALUE;
         REG_CTRL: begin
            wb_dat_o[NBUF-1:0] = ctrl_en;
            wb_dat_o[16]       = ctrl_oneshot;
         end
         REG_SEL: begin
            for (int b = 0; b < NBUF; b++)
               wb_dat_o[4*b +: 4] = sel[b];
         end
         REG_LEN:  wb_dat_o[15:0] = len;
         REG_STATUS: begin
            for (int b = 0; b < NBUF; b++) begin
               wb_dat_o[b]     = (state[b] == ST_DONE);
               wb_dat_o[8 + b] = (state[b] == ST_CAPT);
            end
         end
         default: wb_dat_o = '0;
      endcase
   end

   // A capturing buffer stops taking beats once cnt reaches LEN. This keeps a
   // LEN=0 capture from grabbing a beat in its single CAPT cycle.
   always_comb begin
      for (int b = 0; b < NBUF; b++) begin
         eligible[b]   = (state[b] == ST_PASS) || ((state[b] == ST_CAPT) && (cnt[b] < len));
         stage_free[b] = ~stage_valid[b] | buf_tready[b];
      end
   end

   // Fork rule: a channel is ready only when every loading buffer that selects
   // it can take the beat. Unselected channels are always ready and drop data.
   always_comb begin
      adc_tready = '1;
      for (int c = 0; c < NCHAN; c++) begin
         for (int b = 0; b < NBUF; b++) begin
            if (eligible[b] && (sel[b] == 4'(c)) && !stage_free[b])
               adc_tready[c] = 1'b0;
         end
      end
   end

   // Per-buffer source mux. A SEL value >= NCHAN matches no channel, so that
   // buffer never loads.
   always_comb begin
      for (int b = 0; b < NBUF; b++) begin
         src_data[b] = '0;
         load[b]     = 1'b0;
         for (int c = 0; c < NCHAN; c++) begin
            if (sel[b] == 4'(c)) begin
               src_data[b] = adc_tdata[c*DW +: DW];
               load[b]     = eligible[b] & adc_tvalid[c] & adc_tready[c];
            end
         end
      end
   end

   // Per-buffer mode FSM and capture counter. ARM has priority so that a
   // single CTRL write can both enable a buffer and start its capture.
   always_ff @(posedge wb_clk_i) begin
      for (int b = 0; b < NBUF; b++) begin
         if (wb_rst_i) begin
            state[b] <= ST_OFF;
            cnt[b]   <= '0;
         end else if (arm && wb_dat_i[b]) begin
            state[b] <= ST_CAPT;
            cnt[b]   <= '0;
         end else if (!ctrl_en[b]) begin
            state[b] <= ST_OFF;
         end else begin
            case (state[b])
               ST_OFF: begin
                  if (!ctrl_oneshot)
                     state[b] <= ST_PASS;
               end
               ST_CAPT: begin
                  if (cnt[b] >= len) begin
                     state[b] <= ST_DONE;
                  end else if (load[b]) begin
                     if (cnt[b] != 16'hFFFF)
                        cnt[b] <= cnt[b] + 16'd1;
                     if (cnt[b] + 16'd1 == len)
                        state[b] <= ST_DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // One-entry output stages. A full stage is held until the sink takes it,
   // even after its buffer has left the active states.
   always_ff @(posedge wb_clk_i) begin
      for (int b = 0; b < NBUF; b++) begin
         if (wb_rst_i) begin
            stage_valid[b] <= 1'b0;
         end else if (load[b]) begin
            stage_valid[b] <= 1'b1;
            stage_data[b]  <= src_data[b];
         end else if (buf_tready[b]) begin
            stage_valid[b] <= 1'b0;
         end
      end
   end

   always_comb begin
      buf_tdata = '0;
      for (int b = 0; b < NBUF; b++)
         buf_tdata[b*DW +: DW] = stage_data[b];
   end

endmodule

// File: tb/tb_stream_capture_router.sv
// tb_stream_capture_router
//   Self-checking bench for stream_capture_router (NCHAN=8, NBUF=4, DW=128).
//   A scoreboard process queues each input beat for every buffer the bench
//   expects to receive it, and compares against buffer output handshakes.

module tb_stream_capture_router;

   localparam int NCHAN = 8;
   localparam int NBUF  = 4;
   localparam int DW    = 128;

   logic                clk = 1'b0;
   logic                rst;
   logic                cyc, stb, we;
   logic [21:0]         adr;
   logic [31:0]         dat_i;
   logic [3:0]          sel_i;
   logic [31:0]         dat_o;
   logic                ack, err, rty;
   logic [NCHAN*DW-1:0] adc_tdata;
   logic [NCHAN-1:0]    adc_tvalid;
   logic [NCHAN-1:0]    adc_tready;
   logic [NBUF*DW-1:0]  buf_tdata;
   logic [NBUF-1:0]     buf_tvalid;
   logic [NBUF-1:0]     buf_tready;

   int                  checks   = 0;
   int                  failures = 0;
   logic [DW-1:0]       exp_q [NBUF][$];
   int                  model_src [NBUF];
   int                  model_rem [NBUF];
   int                  out_count [NBUF];

   always #5 clk = ~clk;

   stream_capture_router #(.NCHAN(NCHAN), .NBUF(NBUF), .DW(DW)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_adr_i   (adr),
      .wb_dat_i   (dat_i),
      .wb_sel_i   (sel_i),
      .wb_dat_o   (dat_o),
      .wb_ack_o   (ack),
      .wb_err_o   (err),
      .wb_rty_o   (rty),
      .adc_tdata  (adc_tdata),
      .adc_tvalid (adc_tvalid),
      .adc_tready (adc_tready),
      .buf_tdata  (buf_tdata),
      .buf_tvalid (buf_tvalid),
      .buf_tready (buf_tready)
   );

   function automatic logic [DW-1:0] make_beat(input int ch, input int idx);
      return {32'hB000_0000 | 32'(ch), 32'(idx), ~32'(idx), 32'hC0FF_EE00 + 32'(idx)};
   endfunction

   // Scoreboard: pop/compare on output handshakes, push on input handshakes.
   task automatic scoreboard_monitor();
      logic [DW-1:0] exp;
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int b = 0; b < NBUF; b++) exp_q[b].delete();
         end else begin
            for (int b = 0; b < NBUF; b++) begin
               if (buf_tvalid[2'(b)] && buf_tready[2'(b)]) begin
                  out_count[b]++;
                  checks++;
                  if (exp_q[b].size() == 0) begin
                     failures++;
                     $display("[TB] FAIL unexpected_beat buf%0d: got %h, required no beat", b, buf_tdata[b*DW +: DW]);
                  end else begin
                     exp = exp_q[b].pop_front();
                     if (buf_tdata[b*DW +: DW] !== exp) begin
                        failures++;
                        $display("[TB] FAIL beat_data buf%0d: got %h, required %h", b, buf_tdata[b*DW +: DW], exp);
                     end
                  end
               end
            end
            for (int c = 0; c < NCHAN; c++) begin
               if (adc_tvalid[3'(c)] && adc_tready[3'(c)]) begin
                  for (int b = 0; b < NBUF; b++) begin
                     if (model_src[b] == c && model_rem[b] != 0) begin
                        exp_q[b].push_back(adc_tdata[c*DW +: DW]);
                        if (model_rem[b] > 0) model_rem[b]--;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_xfer(input logic wr, input logic [21:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = wr; adr = addr; dat_i = wdata;
      lat = -1;
      rdata = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack) begin
            lat = i;
            rdata = dat_o;
            break;
         end
      end
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      checks++;
      if (lat < 0) begin
         failures++;
         $display("[TB] FAIL wb_ack_timeout addr %h: got no ack, required ack within 8 cycles", addr);
      end
   endtask

   task automatic wb_write(input logic [21:0] addr, input logic [31:0] wdata);
      logic [31:0] rd;
      int lat;
      wb_xfer(1'b1, addr, wdata, rd, lat);
   endtask

   task automatic wb_read(input logic [21:0] addr, output logic [31:0] rdata);
      int lat;
      wb_xfer(1'b0, addr, 32'h0, rdata, lat);
   endtask

   // Streams n consecutive beats on one channel, one per cycle when ready.
   task automatic send_beats(input int ch, input int n, input int base);
      logic ok;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         adc_tdata[ch*DW +: DW] = make_beat(ch, base + i);
         adc_tvalid[3'(ch)] = 1'b1;
         ok = 1'b0;
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (adc_tready[3'(ch)]) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL handshake_timeout ch%0d beat %0d: got tready=0, required 1 within 50 cycles", ch, i);
         end
      end
      @(posedge clk);
      #1;
      adc_tvalid[3'(ch)] = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      @(negedge clk);
      checks++;
      if (buf_tvalid !== 4'b0) begin failures++; $display("[TB] FAIL reset_tvalid: got %b, required 0000", buf_tvalid); end
      checks++;
      if (ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b, required 0", ack); end
      checks++;
      if (adc_tready !== 8'hFF) begin failures++; $display("[TB] FAIL reset_tready: got %h, required ff", adc_tready); end
      checks++;
      if ({err, rty} !== 2'b00) begin failures++; $display("[TB] FAIL err_rty: got %b, required 00", {err, rty}); end
      wb_read(22'h004, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_ctrl: got %h, required 00000000", rd); end
      wb_read(22'h008, rd);
      checks++;
      if (rd !== 32'h0000_3210) begin failures++; $display("[TB] FAIL reset_sel: got %h, required 00003210", rd); end
      wb_read(22'h00C, rd);
      checks++;
      if (rd !== 32'h0000_0100) begin failures++; $display("[TB] FAIL reset_len: got %h, required 00000100", rd); end
      wb_read(22'h010, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_status: got %h, required 00000000", rd); end
      wb_write(22'h01C, 32'hFFFF_FFFF);
      wb_read(22'h01C, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL unmapped_read: got %h, required 00000000", rd); end
      wb_read(22'h00C, rd);
      checks++;
      if (rd !== 32'h0000_0100) begin failures++; $display("[TB] FAIL unmapped_write_len: got %h, required 00000100", rd); end
   endtask

   task automatic test_id();
      logic [31:0] rd;
      int lat;
      wb_xfer(1'b0, 22'h000, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h4253_4331) begin failures++; $display("[TB] FAIL id_value: got %h, required 42534331", rd); end
      checks++;
      if (lat != 1) begin failures++; $display("[TB] FAIL id_ack_latency: got %0d, required 1", lat); end
   endtask

   task automatic test_pass_through();
      int start;
      buf_tready = 4'hF;
      wb_write(22'h008, 32'h0000_3215);
      model_src[0] = 5; model_rem[0] = -1;
      wb_write(22'h004, 32'h0000_0001);
      start = out_count[0];
      adc_tdata[0 +: DW] = make_beat(0, 900);
      adc_tvalid[0] = 1'b1;
      @(posedge clk);
      #1;
      adc_tdata[5*DW +: DW] = make_beat(5, 0);
      adc_tvalid[5] = 1'b1;
      @(negedge clk);
      checks++;
      if (adc_tready[5] !== 1'b1) begin failures++; $display("[TB] FAIL pass_ready_ch5: got %b, required 1", adc_tready[5]); end
      @(posedge clk);
      #1;
      adc_tvalid[5] = 1'b0;
      @(negedge clk);
      checks++;
      if (buf_tvalid[0] !== 1'b1 || buf_tdata[0 +: DW] !== make_beat(5, 0)) begin
         failures++;
         $display("[TB] FAIL pass_latency: got valid=%b data=%h, required valid=1 data=%h", buf_tvalid[0], buf_tdata[0 +: DW], make_beat(5, 0));
      end
      checks++;
      if (adc_tready[0] !== 1'b1) begin failures++; $display("[TB] FAIL pass_ready_ch0: got %b, required 1", adc_tready[0]); end
      send_beats(5, 9, 1);
      idle(3);
      checks++;
      if (out_count[0] - start != 10) begin failures++; $display("[TB] FAIL pass_count: got %0d, required 10", out_count[0] - start); end
      checks++;
      if (exp_q[0].size() != 0) begin failures++; $display("[TB] FAIL pass_pending: got %0d, required 0", exp_q[0].size()); end
      adc_tvalid[0] = 1'b0;
      wb_write(22'h004, 32'h0);
      model_src[0] = -1;
      idle(3);
   endtask

   task automatic test_oneshot();
      logic [31:0] rd;
      int start;
      wb_write(22'h008, 32'h0000_3210);
      wb_write(22'h00C, 32'h0000_0004);
      model_src[0] = 0; model_rem[0] = 4;
      start = out_count[0];
      wb_write(22'h004, 32'h8001_0001);
      send_beats(0, 5, 100);
      idle(3);
      checks++;
      if (out_count[0] - start != 4) begin failures++; $display("[TB] FAIL oneshot_count: got %0d, required 4", out_count[0] - start); end
      checks++;
      if (exp_q[0].size() != 0) begin failures++; $display("[TB] FAIL oneshot_pending: got %0d, required 0", exp_q[0].size()); end
      wb_read(22'h010, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("[TB] FAIL oneshot_status: got %h, required 00000001", rd); end
      wb_write(22'h004, 32'h0);
      model_src[0] = -1;
      wb_read(22'h010, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL disable_status: got %h, required 00000000", rd); end
   endtask

   task automatic test_fork_backpressure();
      int start0, start1;
      logic ok;
      wb_write(22'h008, 32'h0000_3222);
      model_src[0] = 2; model_rem[0] = -1;
      model_src[1] = 2; model_rem[1] = -1;
      buf_tready = 4'b1101;
      wb_write(22'h004, 32'h0000_0003);
      start0 = out_count[0];
      start1 = out_count[1];
      @(posedge clk);
      #1;
      adc_tdata[2*DW +: DW] = make_beat(2, 200);
      adc_tvalid[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (adc_tready[2] !== 1'b1) begin failures++; $display("[TB] FAIL fork_ready_free: got %b, required 1", adc_tready[2]); end
      @(posedge clk);
      #1;
      adc_tdata[2*DW +: DW] = make_beat(2, 201);
      @(negedge clk);
      checks++;
      if (adc_tready[2] !== 1'b0) begin failures++; $display("[TB] FAIL fork_ready_blocked: got %b, required 0", adc_tready[2]); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (adc_tready[2] !== 1'b0 || buf_tvalid[1:0] !== 2'b10) begin
            failures++;
            $display("[TB] FAIL fork_hold cycle %0d: got tready=%b tvalid=%b, required tready=0 tvalid=10", i, adc_tready[2], buf_tvalid[1:0]);
         end
      end
      @(posedge clk);
      #1;
      buf_tready = 4'hF;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (adc_tready[2]) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL fork_release: got tready=0, required 1 within 20 cycles"); end
      @(posedge clk);
      #1;
      adc_tvalid[2] = 1'b0;
      send_beats(2, 6, 202);
      idle(3);
      checks++;
      if (out_count[0] - start0 != 8 || out_count[1] - start1 != 8) begin
         failures++;
         $display("[TB] FAIL fork_count: got %0d/%0d, required 8/8", out_count[0] - start0, out_count[1] - start1);
      end
      checks++;
      if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
         failures++;
         $display("[TB] FAIL fork_pending: got %0d/%0d, required 0/0", exp_q[0].size(), exp_q[1].size());
      end
      wb_write(22'h004, 32'h0);
      model_src[0] = -1; model_src[1] = -1;
      idle(2);
   endtask

   task automatic test_boundaries();
      logic [31:0] rd;
      int start;
      // LEN=0 capture completes with no beats.
      wb_write(22'h008, 32'h0000_3210);
      wb_write(22'h00C, 32'h0);
      model_src[0] = 0; model_rem[0] = 0;
      start = out_count[0];
      wb_write(22'h004, 32'h8001_0001);
      wb_read(22'h010, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("[TB] FAIL len0_status: got %h, required 00000001", rd); end
      send_beats(0, 3, 300);
      idle(3);
      checks++;
      if (out_count[0] - start != 0) begin failures++; $display("[TB] FAIL len0_count: got %0d, required 0", out_count[0] - start); end
      wb_write(22'h004, 32'h0);
      model_src[0] = -1;

      // Re-ARM part way through a capture restarts the count.
      wb_write(22'h00C, 32'h0000_0003);
      model_src[0] = 0; model_rem[0] = 3;
      start = out_count[0];
      wb_write(22'h004, 32'h8001_0001);
      send_beats(0, 2, 400);
      idle(2);
      wb_read(22'h010, rd);
      checks++;
      if (rd !== 32'h0000_0100) begin failures++; $display("[TB] FAIL rearm_mid_status: got %h, required 00000100", rd); end
      model_rem[0] = 3;
      wb_write(22'h004, 32'h8001_0001);
      send_beats(0, 4, 410);
      idle(3);
      checks++;
      if (out_count[0] - start != 5) begin failures++; $display("[TB] FAIL rearm_count: got %0d, required 5", out_count[0] - start); end
      checks++;
      if (exp_q[0].size() != 0) begin failures++; $display("[TB] FAIL rearm_pending: got %0d, required 0", exp_q[0].size()); end
      wb_read(22'h010, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("[TB] FAIL rearm_status: got %h, required 00000001", rd); end
      wb_write(22'h004, 32'h0);
      model_src[0] = -1;

      // Disabling with a full, stalled stage keeps the beat until accepted.
      buf_tready[0] = 1'b0;
      model_src[0] = 0; model_rem[0] = -1;
      wb_write(22'h004, 32'h0000_0001);
      send_beats(0, 1, 500);
      wb_write(22'h004, 32'h0);
      model_src[0] = -1;
      idle(3);
      @(negedge clk);
      checks++;
      if (buf_tvalid[0] !== 1'b1 || buf_tdata[0 +: DW] !== make_beat(0, 500)) begin
         failures++;
         $display("[TB] FAIL disable_hold: got valid=%b data=%h, required valid=1 data=%h", buf_tvalid[0], buf_tdata[0 +: DW], make_beat(0, 500));
      end
      checks++;
      if (adc_tready[0] !== 1'b1) begin failures++; $display("[TB] FAIL disable_ready: got %b, required 1", adc_tready[0]); end
      @(posedge clk);
      #1;
      buf_tready[0] = 1'b1;
      idle(2);
      @(negedge clk);
      checks++;
      if (buf_tvalid[0] !== 1'b0 || exp_q[0].size() != 0) begin
         failures++;
         $display("[TB] FAIL disable_drain: got valid=%b pending=%0d, required valid=0 pending=0", buf_tvalid[0], exp_q[0].size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      buf_tready = 4'h0;
      wb_write(22'h008, 32'h0000_3200);
      wb_write(22'h00C, 32'h0000_0005);
      model_src[0] = 0; model_rem[0] = 5;
      model_src[1] = 0; model_rem[1] = 5;
      wb_write(22'h004, 32'h8001_0003);
      send_beats(0, 1, 600);
      wb_read(22'h010, rd);
      checks++;
      if (rd !== 32'h0000_0300) begin failures++; $display("[TB] FAIL midcap_status: got %h, required 00000300", rd); end
      @(negedge clk);
      checks++;
      if (buf_tvalid !== 4'b0011) begin failures++; $display("[TB] FAIL midcap_full: got %b, required 0011", buf_tvalid); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int b = 0; b < NBUF; b++) model_src[b] = -1;
      @(posedge clk);
      #1;
      checks++;
      if (buf_tvalid !== 4'b0) begin failures++; $display("[TB] FAIL midreset_tvalid: got %b, required 0000", buf_tvalid); end
      rst = 1'b0;
      buf_tready = 4'hF;
      wb_read(22'h004, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL midreset_ctrl: got %h, required 00000000", rd); end
      wb_read(22'h008, rd);
      checks++;
      if (rd !== 32'h0000_3210) begin failures++; $display("[TB] FAIL midreset_sel: got %h, required 00003210", rd); end
      wb_read(22'h00C, rd);
      checks++;
      if (rd !== 32'h0000_0100) begin failures++; $display("[TB] FAIL midreset_len: got %h, required 00000100", rd); end
      wb_read(22'h010, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL midreset_status: got %h, required 00000000", rd); end
      checks++;
      if (adc_tready !== 8'hFF) begin failures++; $display("[TB] FAIL midreset_tready: got %h, required ff", adc_tready); end
   endtask

   initial begin
      rst        = 1'b1;
      cyc        = 1'b0;
      stb        = 1'b0;
      we         = 1'b0;
      adr        = '0;
      dat_i      = '0;
      sel_i      = 4'hF;
      adc_tdata  = '0;
      adc_tvalid = '0;
      buf_tready = '0;
      for (int b = 0; b < NBUF; b++) begin
         model_src[b] = -1;
         model_rem[b] = 0;
         out_count[b] = 0;
      end
      fork
         scoreboard_monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      test_reset();
      test_id();
      test_pass_through();
      test_oneshot();
      test_fork_backpressure();
      test_boundaries();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
